// File: rtl/cpu_pkg.sv
// Shared definitions for the SAP-style CPU: opcodes, T-state encoding and
// control-word bit positions used by the sequencer and the datapath top.
package cpu_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  localparam int CTRL_W = 12;

  localparam int unsigned CB_EN_PC     = 0;
  localparam int unsigned CB_OE_PC     = 1;
  localparam int unsigned CB_LOAD_MAR  = 2;
  localparam int unsigned CB_OE_RAM    = 3;
  localparam int unsigned CB_LOAD_IR   = 4;
  localparam int unsigned CB_OE_IR     = 5;
  localparam int unsigned CB_LOAD_ACC  = 6;
  localparam int unsigned CB_OE_ACC    = 7;
  localparam int unsigned CB_SUB       = 8;
  localparam int unsigned CB_OE_ALU    = 9;
  localparam int unsigned CB_LOAD_BREG = 10;
  localparam int unsigned CB_LOAD_OR   = 11;

  // One-hot mask for a single control-word field.
  function automatic logic [CTRL_W-1:0] cbit(input int unsigned idx);
    return 12'h001 << idx;
  endfunction

endpackage

// File: rtl/step_pulse.sv
// Turns the debounced step level into a single-cycle pulse on its rising edge.
module step_pulse (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic step_i,
  output logic pulse_o
);

  logic sync_q;
  logic prev_q;

  // Sample the step level and remember the previous sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= step_i;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/controller_sequencer.sv
// Six-state T-ring controller: decodes T-state and opcode into the control
// word, supports free-run and single-step, and latches HLT.
module controller_sequencer
  import cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  opcode,
  input  logic        run,
  input  logic        step,
  output logic [5:0]  tstate,
  output logic [11:0] ctrl,
  output logic        halted
);

  tstate_e     state_q;
  tstate_e     state_d;
  logic        halted_q;
  logic        halted_d;
  logic        step_pulse_s;
  logic        active_s;
  logic        hlt_hit_s;
  logic [11:0] ctrl_c;

  step_pulse u_step_pulse (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .step_i  (step),
    .pulse_o (step_pulse_s)
  );

  assign active_s  = (run | step_pulse_s) & ~halted_q;
  assign hlt_hit_s = (state_q == T4) && (opcode == OP_HLT);

  // Ring advance; an HLT in T4 freezes the ring and latches halted instead.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (active_s) begin
      if (hlt_hit_s) begin
        halted_d = 1'b1;
      end else begin
        case (state_q)
          T1:      state_d = T2;
          T2:      state_d = T3;
          T3:      state_d = T4;
          T4:      state_d = T5;
          T5:      state_d = T6;
          T6:      state_d = T1;
          default: state_d = T1;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Control word decode; RESET gating keeps ctrl quiet while reset is held.
  always_comb begin
    ctrl_c = 12'h000;
    if (active_s && RESET) begin
      case (state_q)
        T1: ctrl_c = cbit(CB_OE_PC) | cbit(CB_LOAD_MAR);
        T2: ctrl_c = cbit(CB_EN_PC);
        T3: ctrl_c = cbit(CB_OE_RAM) | cbit(CB_LOAD_IR);
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: ctrl_c = cbit(CB_OE_IR) | cbit(CB_LOAD_MAR);
            OP_OUT:                 ctrl_c = cbit(CB_OE_ACC) | cbit(CB_LOAD_OR);
            default:                ctrl_c = 12'h000;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA:  ctrl_c = cbit(CB_OE_RAM) | cbit(CB_LOAD_ACC);
            OP_ADD:  ctrl_c = cbit(CB_OE_RAM) | cbit(CB_LOAD_BREG);
            OP_SUB:  ctrl_c = cbit(CB_OE_RAM) | cbit(CB_LOAD_BREG) | cbit(CB_SUB);
            default: ctrl_c = 12'h000;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD:  ctrl_c = cbit(CB_OE_ALU) | cbit(CB_LOAD_ACC);
            OP_SUB:  ctrl_c = cbit(CB_OE_ALU) | cbit(CB_LOAD_ACC) | cbit(CB_SUB);
            default: ctrl_c = 12'h000;
          endcase
        end
        default: ctrl_c = 12'h000;
      endcase
    end else begin
      ctrl_c = 12'h000;
    end
  end

  // State and halt latch.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  assign tstate = state_q;
  assign ctrl   = ctrl_c;
  assign halted = halted_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Self-checking bench for controller_sequencer: per-cycle reference model plus
// directed literal checks of fetch/execute words, stepping, HLT and reset.
module tb_controller_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  opcode;
  logic        run;
  logic        step;
  logic [5:0]  tstate;
  logic [11:0] ctrl;
  logic        halted;

  int checks = 0;
  int errors = 0;

  controller_sequencer dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .opcode (opcode),
    .run    (run),
    .step   (step),
    .tstate (tstate),
    .ctrl   (ctrl),
    .halted (halted)
  );

  always #5 CLK = ~CLK;

  localparam logic [11:0] M_EN_PC  = 12'h001;
  localparam logic [11:0] M_OE_PC  = 12'h002;
  localparam logic [11:0] M_LD_MAR = 12'h004;
  localparam logic [11:0] M_OE_RAM = 12'h008;
  localparam logic [11:0] M_LD_IR  = 12'h010;
  localparam logic [11:0] M_OE_IR  = 12'h020;
  localparam logic [11:0] M_LD_ACC = 12'h040;
  localparam logic [11:0] M_OE_ACC = 12'h080;
  localparam logic [11:0] M_SUB    = 12'h100;
  localparam logic [11:0] M_OE_ALU = 12'h200;
  localparam logic [11:0] M_LD_B   = 12'h400;
  localparam logic [11:0] M_LD_OR  = 12'h800;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Micro-instruction table: what an active cycle in step t of opcode op drives.
  function automatic logic [11:0] micro(input int t, input logic [3:0] op);
    bit lda = (op == 4'b0000);
    bit add = (op == 4'b0001);
    bit sb  = (op == 4'b0010);
    bit out = (op == 4'b1110);
    logic [11:0] s = sb ? M_SUB : 12'h000;
    if (t == 1) return M_OE_PC | M_LD_MAR;
    if (t == 2) return M_EN_PC;
    if (t == 3) return M_OE_RAM | M_LD_IR;
    if (t == 4) return (lda || add || sb) ? (M_OE_IR | M_LD_MAR) : (out ? (M_OE_ACC | M_LD_OR) : 12'h000);
    if (t == 5) return lda ? (M_OE_RAM | M_LD_ACC) : ((add || sb) ? (M_OE_RAM | M_LD_B | s) : 12'h000);
    if (t == 6) return (add || sb) ? (M_OE_ALU | M_LD_ACC | s) : 12'h000;
    return 12'h000;
  endfunction

  function automatic int oe_bits(input logic [11:0] c);
    return int'(c[1]) + int'(c[3]) + int'(c[5]) + int'(c[7]) + int'(c[9]);
  endfunction

  // Reference model: step number 1..6, halt flag, last two sampled step levels.
  int   t_m = 1;
  int   t_next = 1;
  bit   halted_m = 1'b0;
  bit   h_next = 1'b0;
  bit   samp1 = 1'b0;
  bit   samp2 = 1'b0;

  function automatic bit model_active();
    return !halted_m && (run || (samp1 && !samp2));
  endfunction

  // Compare DUT to model mid-cycle and work out the model's next step.
  always @(negedge CLK) begin
    if (!RESET) begin
      chk("rst_tstate", {6'h00, tstate}, 12'h001);
      chk("rst_ctrl", ctrl, 12'h000);
      chk("rst_halted", {11'h000, halted}, 12'h000);
      t_next <= 1;
      h_next <= 1'b0;
    end else begin
      chk("m_tstate", {6'h00, tstate}, 12'h001 << (t_m - 1));
      chk("m_ctrl", ctrl, model_active() ? micro(t_m, opcode) : 12'h000);
      chk("m_halted", {11'h000, halted}, {11'h000, halted_m});
      chk("m_one_oe", (oe_bits(ctrl) <= 1) ? 12'h001 : 12'h000, 12'h001);
      if (model_active() && t_m == 4 && opcode == 4'b1111) begin
        t_next <= t_m;
        h_next <= 1'b1;
      end else if (model_active()) begin
        t_next <= (t_m % 6) + 1;
        h_next <= halted_m;
      end else begin
        t_next <= t_m;
        h_next <= halted_m;
      end
    end
  end

  // Model state update on the clock, cleared immediately by reset.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      t_m      <= 1;
      halted_m <= 1'b0;
      samp1    <= 1'b0;
      samp2    <= 1'b0;
    end else begin
      t_m      <= t_next;
      halted_m <= h_next;
      samp1    <= step;
      samp2    <= samp1;
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Six free-running cycles of one instruction from T1, literal words T1 first.
  task automatic run_instr(input string name, input logic [3:0] op, input logic [5:0][11:0] exp_c);
    opcode = op;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk({name, "_ts"}, {6'h00, tstate}, 12'h001 << i);
      chk({name, "_ctrl"}, ctrl, exp_c[5-i]);
      next_cycle();
    end
  endtask

  // Hold step high, then low, and confirm exactly one active cycle occurred.
  task automatic pulse_step(input string name, input int hold, input logic [11:0] exp_c,
                            input logic [5:0] exp_t);
    int cnt = 0;
    logic [11:0] seen = 12'h000;
    step = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      if (ctrl != 12'h000) begin
        cnt++;
        seen = ctrl;
      end
      next_cycle();
    end
    step = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
    end
    @(negedge CLK);
    chk({name, "_count"}, 12'(cnt), 12'h001);
    chk({name, "_ctrl"}, seen, exp_c);
    chk({name, "_ts"}, {6'h00, tstate}, {6'h00, exp_t});
    next_cycle();
  endtask

  initial begin
    RESET  = 1'b0;
    run    = 1'b1;
    step   = 1'b0;
    opcode = 4'b0000;
    repeat (2) @(negedge CLK);
    chk("reset_ts", {6'h00, tstate}, 12'h001);
    chk("reset_ctrl_gated", ctrl, 12'h000);
    next_cycle();
    RESET = 1'b1;

    run_instr("lda", 4'b0000, {12'h006, 12'h001, 12'h018, 12'h024, 12'h048, 12'h000});
    run_instr("sub", 4'b0010, {12'h006, 12'h001, 12'h018, 12'h024, 12'h508, 12'h340});
    run_instr("add", 4'b0001, {12'h006, 12'h001, 12'h018, 12'h024, 12'h408, 12'h240});
    run_instr("out", 4'b1110, {12'h006, 12'h001, 12'h018, 12'h880, 12'h000, 12'h000});
    run_instr("nop", 4'b0111, {12'h006, 12'h001, 12'h018, 12'h000, 12'h000, 12'h000});

    run    = 1'b0;
    opcode = 4'b0111;
    pulse_step("step1", 10, 12'h006, 6'b000010);
    pulse_step("step2", 3, 12'h001, 6'b000100);
    pulse_step("step3", 3, 12'h018, 6'b001000);

    run = 1'b1;
    @(negedge CLK);
    chk("run_resume_ts", {6'h00, tstate}, 12'h008);
    repeat (3) @(posedge CLK);
    #1;

    opcode = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("hlt_fetch_ts", {6'h00, tstate}, 12'h001 << i);
      chk("hlt_pre_halted", {11'h000, halted}, 12'h000);
      next_cycle();
    end
    for (int i = 0; i < 20; i++) begin
      run  = ((i % 2) == 1);
      step = ((i % 4) >= 2);
      @(negedge CLK);
      chk("hlt_hold_ts", {6'h00, tstate}, 12'h008);
      chk("hlt_hold_ctrl", ctrl, 12'h000);
      chk("hlt_halted", {11'h000, halted}, 12'h001);
      next_cycle();
    end
    step  = 1'b0;
    run   = 1'b1;
    RESET = 1'b0;
    #1;
    chk("hlt_rst_ts", {6'h00, tstate}, 12'h001);
    chk("hlt_rst_halted", {11'h000, halted}, 12'h000);
    next_cycle();
    RESET = 1'b1;
    @(negedge CLK);
    chk("post_rst_ctrl", ctrl, 12'h006);
    next_cycle();
    opcode = 4'b0001;
    repeat (3) @(posedge CLK);
    #1;

    chk("midt5_ts", {6'h00, tstate}, 12'h010);
    chk("midt5_ctrl", ctrl, 12'h408);
    RESET = 1'b0;
    #1;
    chk("midt5_rst_ts", {6'h00, tstate}, 12'h001);
    chk("midt5_rst_ctrl", ctrl, 12'h000);
    next_cycle();
    RESET = 1'b1;
    @(negedge CLK);
    chk("midt5_first_ctrl", ctrl, 12'h006);
    repeat (4) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
